// File: rtl/riscv_core_scoreboard_param.sv
// riscv_core_scoreboard_param
//
// Issue scoreboard for the decode stage of the riscvooo pipeline. It tracks,
// per architectural register, whether a write is in flight, a one-hot
// latency vector that marks where the producer sits in its pipeline, the
// producing functional unit (FU) and the ROB slot that will hold the result.
// It also tracks a per-FU writeback vector so that two instructions never
// reach writeback in the same cycle.
//
// Parameters:
//   NUM_REGS   architectural register count
//   NUM_FU     functional unit count (FU ids 1..NUM_FU, 0 = none)
//   LAT_W      width of the one-hot latency/stage vectors
//   ROB_W      ROB slot index width
//   BYP_STAGE  a source may be bypassed only when latency bits
//              [LAT_W-1:BYP_STAGE] are all zero
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   src0/src1, src*_en          source register ids and use flags
//   dst, dst_en                 destination id and write flag
//   func_unit, latency          FU id and one-hot writeback latency of the
//                               instruction in decode
//   inst_val_Dhl, stall_Dhl     decode valid / stalled by other causes
//   rob_alloc_slot              ROB slot given to the destination
//   rob_commit_slot/_wen        ROB slot retiring this cycle
//   fu_stalls                   slice k-1 = per-stage stall vector of FU k
//   flush                       squash all in-flight tracking
//   src*_byp_mux_sel            0 = register file, 1..NUM_FU = FU bypass,
//                               NUM_FU+1 = writeback stage, NUM_FU+2 = ROB
//   src*_byp_rob_slot           ROB slot of the source's producer
//   stall_hazard                decode must not issue this cycle
//   wb_mux_sel                  FU owning writeback this cycle, 0 = none
//   wb_conflict                 bit k-1: FU k at writeback while a
//                               higher-id FU also is
//
// Optional feature (macro RISCV_SCOREBOARD_STATS_EN): adds saturating
// raw_stall_cnt / wb_stall_cnt outputs counting the cycles decode was held
// by a source hazard or by a writeback-port hazard respectively.

module riscv_core_scoreboard_param #(
    parameter int NUM_REGS  = 32,
    parameter int NUM_FU    = 3,
    parameter int LAT_W     = 5,
    parameter int ROB_W     = 4,
    parameter int BYP_STAGE = 2,
    localparam int REG_W    = $clog2(NUM_REGS),
    localparam int FU_W     = $clog2(NUM_FU + 1),
    localparam int SEL_W    = $clog2(NUM_FU + 3)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [REG_W-1:0]        src0,
    input  logic                    src0_en,
    input  logic [REG_W-1:0]        src1,
    input  logic                    src1_en,
    input  logic [REG_W-1:0]        dst,
    input  logic                    dst_en,
    input  logic [FU_W-1:0]         func_unit,
    input  logic [LAT_W-1:0]        latency,
    input  logic                    inst_val_Dhl,
    input  logic                    stall_Dhl,
    input  logic [ROB_W-1:0]        rob_alloc_slot,
    input  logic [ROB_W-1:0]        rob_commit_slot,
    input  logic                    rob_commit_wen,
    input  logic [NUM_FU*LAT_W-1:0] fu_stalls,
    input  logic                    flush,
    output logic [SEL_W-1:0]        src0_byp_mux_sel,
    output logic [SEL_W-1:0]        src1_byp_mux_sel,
    output logic [ROB_W-1:0]        src0_byp_rob_slot,
    output logic [ROB_W-1:0]        src1_byp_rob_slot,
    output logic                    stall_hazard,
    output logic [FU_W-1:0]         wb_mux_sel,
    output logic [NUM_FU-1:0]       wb_conflict
`ifdef RISCV_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]             raw_stall_cnt,
    output logic [31:0]             wb_stall_cnt
`endif
);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Advance a one-hot stage vector by one cycle: bits whose stage is
    // stalled hold, the rest move one stage closer to writeback.
    function automatic logic [LAT_W-1:0] advance(
        input logic [LAT_W-1:0] lat,
        input logic [LAT_W-1:0] stall
    );
        return (lat & stall) | ((lat & ~stall) >> 1);
    endfunction

    // Stall vector of the given FU id; FU 0 (none) never stalls.
    function automatic logic [LAT_W-1:0] stall_of(
        input logic [FU_W-1:0]         fu,
        input logic [NUM_FU*LAT_W-1:0] stalls
    );
        logic [LAT_W-1:0] s;
        s = '0;
        for (int k = 1; k <= NUM_FU; k++) begin
            if (fu == FU_W'(k)) begin
                s = stalls[(k-1)*LAT_W +: LAT_W];
            end
        end
        return s;
    endfunction

    // Bypass source for one operand, from the producer's tracking state.
    function automatic logic [SEL_W-1:0] byp_sel(
        input logic [REG_W-1:0] id,
        input logic             pend,
        input logic [LAT_W-1:0] lat,
        input logic [FU_W-1:0]  fu
    );
        logic [SEL_W-1:0] sel;
        if (id == '0 || !pend) begin
            sel = '0;
        end else if (lat == LAT_W'(1)) begin
            sel = SEL_W'(NUM_FU + 1);
        end else if (lat == '0) begin
            sel = SEL_W'(NUM_FU + 2);
        end else begin
            sel = SEL_W'(fu);
        end
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             pending_q [NUM_REGS];
    logic             pending_d [NUM_REGS];
    logic [LAT_W-1:0] lat_q     [NUM_REGS];
    logic [LAT_W-1:0] lat_d     [NUM_REGS];
    logic [FU_W-1:0]  fu_q      [NUM_REGS];
    logic [FU_W-1:0]  fu_d      [NUM_REGS];
    logic [ROB_W-1:0] slot_q    [NUM_REGS];
    logic [ROB_W-1:0] slot_d    [NUM_REGS];
    logic [LAT_W-1:0] wb_lat_q  [NUM_FU];    // index k-1 holds FU k
    logic [LAT_W-1:0] wb_lat_d  [NUM_FU];

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic src0_ok;
    logic src1_ok;
    logic wb_hazard;
    logic accept;
    logic alloc;

    // A source is usable when it is unused, x0, not in flight, or its
    // producer has passed the last stage that cannot be bypassed.
    assign src0_ok = !src0_en || (src0 == '0) || !pending_q[src0]
                     || (lat_q[src0][LAT_W-1:BYP_STAGE] == '0);
    assign src1_ok = !src1_en || (src1 == '0) || !pending_q[src1]
                     || (lat_q[src1][LAT_W-1:BYP_STAGE] == '0);

    // The new instruction would reach writeback in the same cycle as an
    // instruction already in flight on some FU (compared one cycle ahead,
    // since the in-flight vector advances on the issue edge).
    always_comb begin
        // NOTE: every variable written in an always_comb gets a default on
        // entry, so no path leaves it unassigned and no latch is inferred.
        wb_hazard = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (((wb_lat_q[k] >> 1) & latency) != '0) begin
                wb_hazard = 1'b1;
            end
        end
    end

    assign accept       = src0_ok && src1_ok && !wb_hazard && inst_val_Dhl && !flush;
    assign stall_hazard = !accept;
    assign alloc        = accept && !stall_Dhl && dst_en && (dst != '0);

    // ------------------------------------------------------------------
    // Bypass selects
    // ------------------------------------------------------------------
    assign src0_byp_mux_sel  = byp_sel(src0, pending_q[src0], lat_q[src0], fu_q[src0]);
    assign src1_byp_mux_sel  = byp_sel(src1, pending_q[src1], lat_q[src1], fu_q[src1]);
    assign src0_byp_rob_slot = slot_q[src0];
    assign src1_byp_rob_slot = slot_q[src1];

    // ------------------------------------------------------------------
    // Writeback ownership: highest-id FU at writeback wins the mux; every
    // lower FU also at writeback is flagged as conflicting.
    // ------------------------------------------------------------------
    always_comb begin
        logic higher;
        wb_mux_sel  = '0;
        wb_conflict = '0;
        higher      = 1'b0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (wb_lat_q[k][1]) begin
                if (!higher) begin
                    wb_mux_sel = FU_W'(k + 1);
                end
                wb_conflict[k] = higher;
                higher         = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_d[r] = pending_q[r];
            lat_d[r]     = advance(lat_q[r], stall_of(fu_q[r], fu_stalls));
            fu_d[r]      = fu_q[r];
            slot_d[r]    = slot_q[r];
            if (rob_commit_wen && (rob_commit_slot == slot_q[r])) begin
                pending_d[r] = 1'b0;
            end
        end

        // Allocation overrides a commit landing on the same register: the
        // retiring slot belonged to the previous writer.
        if (alloc) begin
            pending_d[dst] = 1'b1;
            lat_d[dst]     = latency;
            fu_d[dst]      = func_unit;
            slot_d[dst]    = rob_alloc_slot;
        end

        for (int k = 0; k < NUM_FU; k++) begin
            wb_lat_d[k] = advance(wb_lat_q[k], fu_stalls[k*LAT_W +: LAT_W]);
            // The writeback port is reserved even for instructions without a
            // destination register.
            if (accept && !stall_Dhl && (func_unit == FU_W'(k + 1))) begin
                wb_lat_d[k] = wb_lat_d[k] | latency;
            end
        end

        // Slots are kept across a flush; they are only meaningful while the
        // entry is pending.
        if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pending_d[r] = 1'b0;
                lat_d[r]     = '0;
                fu_d[r]      = '0;
            end
            for (int k = 0; k < NUM_FU; k++) begin
                wb_lat_d[k] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the per-register arrays are reset, not just the pending
            // bits, because the slot outputs are visible for idle registers.
            for (int r = 0; r < NUM_REGS; r++) begin
                pending_q[r] <= 1'b0;
                lat_q[r]     <= '0;
                fu_q[r]      <= '0;
                slot_q[r]    <= '0;
            end
            for (int k = 0; k < NUM_FU; k++) begin
                wb_lat_q[k] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples the pre-edge values of the others.
            for (int r = 0; r < NUM_REGS; r++) begin
                pending_q[r] <= pending_d[r];
                lat_q[r]     <= lat_d[r];
                fu_q[r]      <= fu_d[r];
                slot_q[r]    <= slot_d[r];
            end
            for (int k = 0; k < NUM_FU; k++) begin
                wb_lat_q[k] <= wb_lat_d[k];
            end
        end
    end

`ifdef RISCV_SCOREBOARD_STATS_EN
    // ------------------------------------------------------------------
    // Stall statistics (saturating)
    // ------------------------------------------------------------------
    logic [31:0] raw_stall_cnt_q;
    logic [31:0] raw_stall_cnt_d;
    logic [31:0] wb_stall_cnt_q;
    logic [31:0] wb_stall_cnt_d;

    always_comb begin
        raw_stall_cnt_d = raw_stall_cnt_q;
        wb_stall_cnt_d  = wb_stall_cnt_q;
        if (inst_val_Dhl && !(src0_ok && src1_ok) && (raw_stall_cnt_q != '1)) begin
            raw_stall_cnt_d = raw_stall_cnt_q + 32'd1;
        end
        if (inst_val_Dhl && src0_ok && src1_ok && wb_hazard && (wb_stall_cnt_q != '1)) begin
            wb_stall_cnt_d = wb_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raw_stall_cnt_q <= '0;
            wb_stall_cnt_q  <= '0;
        end else begin
            raw_stall_cnt_q <= raw_stall_cnt_d;
            wb_stall_cnt_q  <= wb_stall_cnt_d;
        end
    end

    assign raw_stall_cnt = raw_stall_cnt_q;
    assign wb_stall_cnt  = wb_stall_cnt_q;
`endif

endmodule
